sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 4: number of sdram_ack pulses returned for one video burst read.
REQ-002 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 sdram_rd / sdram_wr  output  1 each  command strobes to the SDRAM controller.
REQ-005 sdram_addr_x16  output  24  word address; sdram_wdata  output  16; sdram_wmask  output  2  byte-enables; sdram_burst  output  1  burst-read flag.
REQ-006 sdram_rdata  input  16  read data; sdram_ack  input  1  one pulse per completed word; sdram_rdy  input  1  controller can accept a command.
REQ-007 cpu_sdram_rd / cpu_sdram_wr  input  1 each; cpu_sdram_addr_x16  input  24; cpu_sdram_wdata  input  16; cpu_sdram_wmask  input  2.
REQ-008 cpu_sdram_rdata  output  16; cpu_sdram_ack  output  1; cpu_sdram_rdy  output  1.
REQ-009 video_sdram_rd  input  1; video_sdram_addr_x16  input  24; video_sdram_rdata  output  16; video_sdram_ack  output  1; video_sdram_rdy  output  1.

Function
REQ-010 Each requester SHALL hold its request (rd/wr, address, data, mask) until accepted; a request is accepted in a cycle where it is asserted and that requester's rdy is 1.
REQ-011 Owner state SHALL be IDLE, CPU or VIDEO.
REQ-012 In IDLE with sdram_rdy=1: video_sdram_rdy=1; cpu_sdram_rdy=1 only if video_sdram_rd=0 (video has fixed priority). In CPU or VIDEO, or with sdram_rdy=0, both rdy outputs SHALL be 0.
REQ-013 On acceptance, the command SHALL be forwarded combinationally in the same cycle: sdram_rd/sdram_wr, address, wdata and wmask taken from the winner; sdram_burst=1 only for video.
REQ-014 Video commands SHALL always be reads with sdram_wr=0; sdram_wdata/sdram_wmask SHALL always carry the CPU values.
REQ-015 If the CPU asserts rd and wr together, the command SHALL be issued as a write only.
REQ-016 Acceptance SHALL move the state to the winner's owner on the next edge and load the ack counter with 1 (CPU) or BURST_LEN (video).
REQ-017 sdram_ack SHALL be routed combinationally to the owner's ack output only; the ack counter decrements per ack, and the state returns to IDLE on the edge after the final ack.
REQ-018 Acks arriving in IDLE SHALL be ignored and forwarded to nobody.
REQ-019 sdram_rdata SHALL be broadcast unregistered to cpu_sdram_rdata and video_sdram_rdata.
REQ-020 The cycle carrying the final ack still counts as busy; a new grant SHALL be possible no earlier than the following cycle.
REQ-021 CPU writes SHALL complete on one sdram_ack, exactly like CPU reads.

Reset
REQ-022 While rst_i=1: state IDLE, counters 0, and all strobe, rdy and ack outputs 0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction; later stray acks are ignored per REQ-018.

Configuration
REQ-024 Macro SDRAM_ARB_FAIRNESS_EN defined: a counter tracks consecutive video grants made while a CPU request is pending. At 4, the next IDLE grant SHALL go to the CPU, video_sdram_rdy=0 that cycle, and the counter clears on that CPU grant.
REQ-025 Macro SDRAM_ARB_FAIRNESS_EN undefined: strict video priority per REQ-012, with no fairness counter present.

Structure
REQ-026 Shared package sdram_arb_pkg SHALL hold the owner enum typedef (OWN_IDLE, OWN_CPU, OWN_VIDEO) and the fairness limit constant (4).
REQ-027 Single flat module with no sub-modules; the ack counter is $clog2(BURST_LEN+1) bits wide.

Verification
REQ-028 CPU read at address 0x000010; controller acks once with data 0xBEEF -> cpu_sdram_ack=1 and cpu_sdram_rdata=0xBEEF in that cycle, cpu_sdram_rdy=1 the following cycle.
REQ-029 Video read at address 0x001000 -> sdram_burst=1 and 4 video acks; cpu_sdram_rdy stays 0 until the cycle after the 4th ack.
REQ-030 CPU write (0x1234, wmask 2'b01) and video read requested in the same cycle -> video issued first, CPU write issued after the 4th video ack.
REQ-031 rst_i pulsed after 2 of 4 video acks, then 2 stray acks -> no ack forwarded to anyone; cpu_sdram_rdy=1 after reset.
REQ-032 With SDRAM_ARB_FAIRNESS_EN and video requesting continuously while a CPU read is pending -> CPU granted after exactly 4 video bursts.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM arbiter.
//   owner_t    : which requester currently owns the SDRAM controller
//   FAIR_LIMIT : consecutive video grants tolerated while a CPU request waits
//                (only used when SDRAM_ARB_FAIRNESS_EN is defined)
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      OWN_IDLE  = 2'd0,
      OWN_CPU   = 2'd1,
      OWN_VIDEO = 2'd2
   } owner_t;

   localparam int unsigned FAIR_LIMIT = 4;

endpackage

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM arbiter: one CPU port (read/write, single word) and one
// video port (burst read of BURST_LEN words) share a single SDRAM controller.
// Video has fixed priority. Commands are forwarded combinationally in the
// accepting cycle; the arbiter then stays busy until the owner's last ack.
//
// Optional feature: define SDRAM_ARB_FAIRNESS_EN to force a CPU grant after
// FAIR_LIMIT consecutive video grants made while the CPU was waiting.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   sdram_*                      command/response to the SDRAM controller
//   cpu_sdram_*                  CPU request port (rd/wr/addr/wdata/wmask in,
//                                rdata/ack/rdy out)
//   video_sdram_*                video request port (rd/addr in,
//                                rdata/ack/rdy out)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// OWN_IDLE  | no transaction in flight; grants possible when sdram_rdy=1
// OWN_CPU   | CPU command issued, waiting for its single ack
// OWN_VIDEO | video burst issued, waiting for BURST_LEN acks
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int BURST_LEN = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,

   output logic        sdram_rd,
   output logic        sdram_wr,
   output logic [23:0] sdram_addr_x16,
   output logic [15:0] sdram_wdata,
   output logic [1:0]  sdram_wmask,
   output logic        sdram_burst,
   input  logic [15:0] sdram_rdata,
   input  logic        sdram_ack,
   input  logic        sdram_rdy,

   input  logic        cpu_sdram_rd,
   input  logic        cpu_sdram_wr,
   input  logic [23:0] cpu_sdram_addr_x16,
   input  logic [15:0] cpu_sdram_wdata,
   input  logic [1:0]  cpu_sdram_wmask,
   output logic [15:0] cpu_sdram_rdata,
   output logic        cpu_sdram_ack,
   output logic        cpu_sdram_rdy,

   input  logic        video_sdram_rd,
   input  logic [23:0] video_sdram_addr_x16,
   output logic [15:0] video_sdram_rdata,
   output logic        video_sdram_ack,
   output logic        video_sdram_rdy
);

   localparam int CNT_W = $clog2(BURST_LEN + 1);
   localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

   owner_t           owner;
   logic [CNT_W-1:0] ack_cnt;

   logic cpu_req;
   logic grant_ok;
   logic force_cpu;
   logic cpu_grant;
   logic video_grant;

   assign cpu_req  = cpu_sdram_rd | cpu_sdram_wr;
   // rst_i gates the grant path so rdy/strobes are quiet for the whole reset
   assign grant_ok = ~rst_i & (owner == OWN_IDLE) & sdram_rdy;

`ifdef SDRAM_ARB_FAIRNESS_EN
   localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);
   localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_LIMIT);

   logic [FAIR_W-1:0] fair_cnt;

   assign force_cpu = (fair_cnt == FAIR_MAX) & cpu_req;

   // Counts back-to-back video grants that overtook a waiting CPU request.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fair_cnt <= '0;
      end else if (cpu_grant) begin
         fair_cnt <= '0;
      end else if (video_grant) begin
         if (!cpu_req)
            fair_cnt <= '0;
         else if (fair_cnt != FAIR_MAX)
            fair_cnt <= fair_cnt + 1'b1;
      end
   end
`else
   assign force_cpu = 1'b0;
`endif

   assign video_sdram_rdy = grant_ok & ~force_cpu;
   assign cpu_sdram_rdy   = grant_ok & (~video_sdram_rd | force_cpu);

   // The rdy terms above are mutually exclusive whenever both could fire.
   assign video_grant = video_sdram_rd & video_sdram_rdy;
   assign cpu_grant   = cpu_req & cpu_sdram_rdy;

   // rd+wr together from the CPU is issued as a write only.
   assign sdram_rd       = video_grant | (cpu_grant & ~cpu_sdram_wr);
   assign sdram_wr       = cpu_grant & cpu_sdram_wr;
   assign sdram_burst    = video_grant;
   assign sdram_addr_x16 = video_grant ? video_sdram_addr_x16 : cpu_sdram_addr_x16;
   assign sdram_wdata    = cpu_sdram_wdata;
   assign sdram_wmask    = cpu_sdram_wmask;

   assign cpu_sdram_ack     = (owner == OWN_CPU)   & sdram_ack;
   assign video_sdram_ack   = (owner == OWN_VIDEO) & sdram_ack;
   assign cpu_sdram_rdata   = sdram_rdata;
   assign video_sdram_rdata = sdram_rdata;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner   <= OWN_IDLE;
         ack_cnt <= '0;
      end else begin
         case (owner)
            OWN_IDLE: begin
               if (video_grant) begin
                  owner   <= OWN_VIDEO;
                  ack_cnt <= BURST_CNT;
               end else if (cpu_grant) begin
                  owner   <= OWN_CPU;
                  ack_cnt <= ONE_CNT;
               end
            end
            default: begin
               if (sdram_ack) begin
                  ack_cnt <= ack_cnt - 1'b1;
                  if (ack_cnt == ONE_CNT)
                     owner <= OWN_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a transaction-level
// reference model (who owns the bus and how many acks it still expects).
module tb_sdram_arbiter;

   localparam int BL = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        sdram_rd, sdram_wr, sdram_burst;
   logic [23:0] sdram_addr_x16;
   logic [15:0] sdram_wdata;
   logic [1:0]  sdram_wmask;
   logic [15:0] sdram_rdata;
   logic        sdram_ack, sdram_rdy;
   logic        cpu_sdram_rd, cpu_sdram_wr;
   logic [23:0] cpu_sdram_addr_x16;
   logic [15:0] cpu_sdram_wdata;
   logic [1:0]  cpu_sdram_wmask;
   logic [15:0] cpu_sdram_rdata;
   logic        cpu_sdram_ack, cpu_sdram_rdy;
   logic        video_sdram_rd;
   logic [23:0] video_sdram_addr_x16;
   logic [15:0] video_sdram_rdata;
   logic        video_sdram_ack, video_sdram_rdy;

   always #5 clk_i = ~clk_i;

   sdram_arbiter #(.BURST_LEN(BL)) dut (
      .clk_i                (clk_i),
      .rst_i                (rst_i),
      .sdram_rd             (sdram_rd),
      .sdram_wr             (sdram_wr),
      .sdram_addr_x16       (sdram_addr_x16),
      .sdram_wdata          (sdram_wdata),
      .sdram_wmask          (sdram_wmask),
      .sdram_burst          (sdram_burst),
      .sdram_rdata          (sdram_rdata),
      .sdram_ack            (sdram_ack),
      .sdram_rdy            (sdram_rdy),
      .cpu_sdram_rd         (cpu_sdram_rd),
      .cpu_sdram_wr         (cpu_sdram_wr),
      .cpu_sdram_addr_x16   (cpu_sdram_addr_x16),
      .cpu_sdram_wdata      (cpu_sdram_wdata),
      .cpu_sdram_wmask      (cpu_sdram_wmask),
      .cpu_sdram_rdata      (cpu_sdram_rdata),
      .cpu_sdram_ack        (cpu_sdram_ack),
      .cpu_sdram_rdy        (cpu_sdram_rdy),
      .video_sdram_rd       (video_sdram_rd),
      .video_sdram_addr_x16 (video_sdram_addr_x16),
      .video_sdram_rdata    (video_sdram_rdata),
      .video_sdram_ack      (video_sdram_ack),
      .video_sdram_rdy      (video_sdram_rdy)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: current bus owner (0 none, 1 cpu, 2 video), acks still
   // owed to it, and video grants that overtook a waiting CPU.
   int m_owner = 0;
   int m_left  = 0;
   int m_fair  = 0;

   bit ca, va;

   // Inputs are already driven (just after a falling edge). Predict and check
   // every output, take the rising edge, advance the model, return at the
   // next falling edge.
   task automatic cycle(output bit c_acc, output bit v_acc);
      bit cpend, force_c, free, e_crdy, e_vrdy, e_rd, e_wr;
      logic [23:0] e_addr;
      #1;
      cpend   = cpu_sdram_rd | cpu_sdram_wr;
      force_c = 1'b0;
`ifdef SDRAM_ARB_FAIRNESS_EN
      force_c = (m_fair >= 4) && cpend;
`endif
      free   = !rst_i && (m_owner == 0) && sdram_rdy;
      e_vrdy = free && !force_c;
      e_crdy = free && (!video_sdram_rd || force_c);
      v_acc  = video_sdram_rd && e_vrdy;
      c_acc  = cpend && e_crdy;
      e_wr   = c_acc && cpu_sdram_wr;
      e_rd   = v_acc || (c_acc && !cpu_sdram_wr);
      e_addr = v_acc ? video_sdram_addr_x16 : cpu_sdram_addr_x16;

      chk("cpu_rdy",   32'(cpu_sdram_rdy),   32'(e_crdy));
      chk("video_rdy", 32'(video_sdram_rdy), 32'(e_vrdy));
      chk("sdram_rd",  32'(sdram_rd),        32'(e_rd));
      chk("sdram_wr",  32'(sdram_wr),        32'(e_wr));
      chk("burst",     32'(sdram_burst),     32'(v_acc));
      if (e_rd || e_wr)
         chk("addr", 32'(sdram_addr_x16), 32'(e_addr));
      chk("wdata",     32'(sdram_wdata),     32'(cpu_sdram_wdata));
      chk("wmask",     32'(sdram_wmask),     32'(cpu_sdram_wmask));
      chk("cpu_ack",   32'(cpu_sdram_ack),   32'(!rst_i && m_owner == 1 && sdram_ack));
      chk("video_ack", 32'(video_sdram_ack), 32'(!rst_i && m_owner == 2 && sdram_ack));
      chk("cpu_rdata", 32'(cpu_sdram_rdata), 32'(sdram_rdata));
      chk("vid_rdata", 32'(video_sdram_rdata), 32'(sdram_rdata));

      @(posedge clk_i);
      if (rst_i) begin
         m_owner = 0;
         m_left  = 0;
         m_fair  = 0;
      end else if (m_owner == 0) begin
         if (v_acc) begin
            m_owner = 2;
            m_left  = BL;
            m_fair  = cpend ? m_fair + 1 : 0;
         end else if (c_acc) begin
            m_owner = 1;
            m_left  = 1;
            m_fair  = 0;
         end
      end else if (sdram_ack) begin
         m_left--;
         if (m_left == 0)
            m_owner = 0;
      end
      @(negedge clk_i);
   endtask

   task automatic quiet();
      sdram_ack      = 1'b0;
      sdram_rdy      = 1'b1;
      sdram_rdata    = 16'h0;
      cpu_sdram_rd   = 1'b0;
      cpu_sdram_wr   = 1'b0;
      video_sdram_rd = 1'b0;
   endtask

   int acks, vgrants, cgrants;
   bit cpu_pend, vid_pend;

   initial begin
      rst_i                = 1'b1;
      cpu_sdram_addr_x16   = 24'h0;
      cpu_sdram_wdata      = 16'h0;
      cpu_sdram_wmask      = 2'b00;
      video_sdram_addr_x16 = 24'h0;
      quiet();
      video_sdram_rd = 1'b1;
      cpu_sdram_rd   = 1'b1;
      sdram_ack      = 1'b1;
      // Reset: everything quiet even with requests and sdram_rdy present.
      #1;
      chk("rst_cpu_rdy", 32'(cpu_sdram_rdy),   32'(0));
      chk("rst_vid_rdy", 32'(video_sdram_rdy), 32'(0));
      chk("rst_rd",      32'(sdram_rd),        32'(0));
      chk("rst_vid_ack", 32'(video_sdram_ack), 32'(0));
      repeat (2) cycle(ca, va);
      rst_i = 1'b0;
      quiet();
      cycle(ca, va);

      // CPU read, single ack with data.
      cpu_sdram_rd = 1'b1; cpu_sdram_addr_x16 = 24'h000010;
      #1;
      chk("t1_addr", 32'(sdram_addr_x16), 32'h10);
      cycle(ca, va);
      chk("t1_acc", 32'(ca), 32'(1));
      cpu_sdram_rd = 1'b0;
      sdram_ack = 1'b1; sdram_rdata = 16'hBEEF;
      #1;
      chk("t1_ack",   32'(cpu_sdram_ack),   32'(1));
      chk("t1_rdata", 32'(cpu_sdram_rdata), 32'hBEEF);
      chk("t1_busy",  32'(cpu_sdram_rdy),   32'(0));
      cycle(ca, va);
      sdram_ack = 1'b0;
      #1;
      chk("t1_rdy_after", 32'(cpu_sdram_rdy), 32'(1));
      cycle(ca, va);

      // Video burst: CPU locked out until the cycle after the 4th ack.
      video_sdram_rd = 1'b1; video_sdram_addr_x16 = 24'h001000;
      #1;
      chk("t2_burst", 32'(sdram_burst), 32'(1));
      cycle(ca, va);
      video_sdram_rd = 1'b0;
      acks = 0;
      for (int i = 0; i < BL; i++) begin
         sdram_ack = 1'b1; sdram_rdata = 16'(16'hA000 + i);
         #1;
         chk("t2_cpu_rdy_busy", 32'(cpu_sdram_rdy), 32'(0));
         if (video_sdram_ack) acks++;
         cycle(ca, va);
      end
      chk("t2_acks", 32'(acks), 32'(BL));
      sdram_ack = 1'b0;
      #1;
      chk("t2_rdy_after", 32'(cpu_sdram_rdy), 32'(1));
      cycle(ca, va);

      // Simultaneous CPU write and video read: video first.
      cpu_sdram_wr = 1'b1; cpu_sdram_addr_x16 = 24'h000020;
      cpu_sdram_wdata = 16'h1234; cpu_sdram_wmask = 2'b01;
      video_sdram_rd = 1'b1; video_sdram_addr_x16 = 24'h002000;
      #1;
      chk("t3_first_addr", 32'(sdram_addr_x16), 32'h002000);
      chk("t3_first_wr",   32'(sdram_wr),       32'(0));
      cycle(ca, va);
      chk("t3_vid_acc", 32'(va), 32'(1));
      video_sdram_rd = 1'b0;
      sdram_ack = 1'b1;
      for (int i = 0; i < BL; i++) cycle(ca, va);
      sdram_ack = 1'b0;
      #1;
      chk("t3_wr",    32'(sdram_wr),       32'(1));
      chk("t3_rd",    32'(sdram_rd),       32'(0));
      chk("t3_addr",  32'(sdram_addr_x16), 32'h20);
      chk("t3_wdata", 32'(sdram_wdata),    32'h1234);
      chk("t3_wmask", 32'(sdram_wmask),    32'(2'b01));
      cycle(ca, va);
      cpu_sdram_wr = 1'b0;
      sdram_ack = 1'b1;
      #1;
      chk("t3_wr_ack", 32'(cpu_sdram_ack), 32'(1));
      cycle(ca, va);
      quiet();
      cycle(ca, va);

      // Reset in the middle of a burst, then stray acks.
      video_sdram_rd = 1'b1; video_sdram_addr_x16 = 24'h003000;
      cycle(ca, va);
      video_sdram_rd = 1'b0;
      sdram_ack = 1'b1;
      repeat (2) cycle(ca, va);
      rst_i = 1'b1; sdram_ack = 1'b0;
      cycle(ca, va);
      rst_i = 1'b0;
      sdram_ack = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("t4_stray_cpu", 32'(cpu_sdram_ack),   32'(0));
         chk("t4_stray_vid", 32'(video_sdram_ack), 32'(0));
         cycle(ca, va);
      end
      sdram_ack = 1'b0;
      #1;
      chk("t4_rdy", 32'(cpu_sdram_rdy), 32'(1));
      cycle(ca, va);

      // Continuous video with a pending CPU read.
      cpu_sdram_rd = 1'b1; cpu_sdram_addr_x16 = 24'h000040;
      video_sdram_rd = 1'b1;
      sdram_ack = 1'b1;
      vgrants = 0; cgrants = 0;
      for (int i = 0; i < 40 && cgrants == 0; i++) begin
         cycle(ca, va);
         if (va) vgrants++;
         if (ca) cgrants++;
      end
`ifdef SDRAM_ARB_FAIRNESS_EN
      chk("fair_cpu_granted", 32'(cgrants), 32'(1));
      chk("fair_vid_bursts",  32'(vgrants), 32'(4));
`else
      chk("prio_cpu_starved", 32'(cgrants), 32'(0));
`endif
      quiet();
      repeat (BL + 1) cycle(ca, va);

      // Randomized traffic; requesters hold until accepted.
      cpu_pend = 1'b0; vid_pend = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!cpu_pend && $urandom_range(0, 2) == 0) begin
            int r;
            r = $urandom_range(0, 5);
            cpu_sdram_rd       = (r <= 2) || (r == 5);
            cpu_sdram_wr       = (r >= 3);
            cpu_sdram_addr_x16 = 24'($urandom);
            cpu_sdram_wdata    = 16'($urandom);
            cpu_sdram_wmask    = 2'($urandom);
            cpu_pend = 1'b1;
         end
         if (!vid_pend && $urandom_range(0, 2) == 0) begin
            video_sdram_rd       = 1'b1;
            video_sdram_addr_x16 = 24'($urandom);
            vid_pend = 1'b1;
         end
         sdram_rdy   = ($urandom_range(0, 3) != 0);
         sdram_ack   = $urandom_range(0, 1) == 1;
         sdram_rdata = 16'($urandom);
         cycle(ca, va);
         if (ca) begin
            cpu_pend = 1'b0; cpu_sdram_rd = 1'b0; cpu_sdram_wr = 1'b0;
         end
         if (va) begin
            vid_pend = 1'b0; video_sdram_rd = 1'b0;
         end
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
